// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: default depth and Gray/binary conversion used by
// both pointer blocks and the pointer synchronizers.
package fifo_pkg;

    localparam int FIFO_ASIZE = 4;
    localparam int PTR_MAXW   = 32;

    typedef logic [PTR_MAXW-1:0] ptr_word_t;

    // Zero-extended inputs convert correctly, so one wide routine serves every
    // pointer width; callers slice the low ASIZE+1 bits of the result.
    function automatic ptr_word_t bin2gray(input ptr_word_t bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic ptr_word_t gray2bin(input ptr_word_t gray);
        ptr_word_t bin;
        bin = gray;
        bin = bin ^ (bin >> 1);
        bin = bin ^ (bin >> 2);
        bin = bin ^ (bin >> 4);
        bin = bin ^ (bin >> 8);
        bin = bin ^ (bin >> 16);
        return bin;
    endfunction

endpackage

// File: rtl/rptr_empty_if.sv
// Read-side FIFO bundle: pop request and synchronized write pointer in,
// RAM address, Gray read pointer, flags and level out.
interface rptr_empty_if #(
    parameter int ASIZE = fifo_pkg::FIFO_ASIZE
);

    logic             ren;
    logic [ASIZE:0]   r_wptr;
    logic [ASIZE-1:0] raddr;
    logic [ASIZE:0]   rptr;
    logic             rempty;
    logic             ralmost_empty;
    logic [ASIZE:0]   rlevel;
    logic             runderflow;

    modport master (
        output ren,
        output r_wptr,
        input  raddr,
        input  rptr,
        input  rempty,
        input  ralmost_empty,
        input  rlevel,
        input  runderflow
    );

    modport slave (
        input  ren,
        input  r_wptr,
        output raddr,
        output rptr,
        output rempty,
        output ralmost_empty,
        output rlevel,
        output runderflow
    );

endinterface

// File: rtl/rptr_empty.sv
// Read-domain pointer, empty/almost-empty flags, occupancy and sticky
// underflow for the asynchronous FIFO.
module rptr_empty
    import fifo_pkg::*;
#(
    parameter int ASIZE     = FIFO_ASIZE,
    parameter int AE_THRESH = 2
) (
    input  logic         rclk,
    input  logic         rrst,
    rptr_empty_if.slave  rif
);

    localparam logic [ASIZE:0] AE_LIMIT = AE_THRESH[ASIZE:0];

    logic [ASIZE:0] rbin_r;
    logic [ASIZE:0] rptr_r;
    logic           rempty_r;
    logic           ralmost_empty_r;
    logic [ASIZE:0] rlevel_r;
    logic           runderflow_r;

    logic           rinc_s;
    logic [ASIZE:0] rbinnext_s;
    logic [ASIZE:0] rgraynext_s;
    logic [ASIZE:0] wbin_s;
    logic [ASIZE:0] level_s;
    ptr_word_t      gray_wide_s;
    ptr_word_t      wbin_wide_s;
    logic           unused_s;

    // Next-pointer, write-pointer decode and post-pop occupancy
    always_comb begin
        rinc_s      = rif.ren & ~rempty_r;
        rbinnext_s  = rbin_r + {{ASIZE{1'b0}}, rinc_s};
        gray_wide_s = bin2gray(ptr_word_t'(rbinnext_s));
        rgraynext_s = gray_wide_s[ASIZE:0];
        wbin_wide_s = gray2bin(ptr_word_t'(rif.r_wptr));
        wbin_s      = wbin_wide_s[ASIZE:0];
        // Modular difference; a full FIFO yields exactly 2**ASIZE.
        level_s     = wbin_s - rbinnext_s;
    end

    // Upper bits of the wide helper results are zero by construction.
    assign unused_s = ^{gray_wide_s[PTR_MAXW-1:ASIZE+1], wbin_wide_s[PTR_MAXW-1:ASIZE+1]};

    // Pointer, flag, level and underflow registers
    always_ff @(posedge rclk) begin
        if (rrst) begin
            rbin_r          <= '0;
            rptr_r          <= '0;
            rempty_r        <= 1'b1;
            ralmost_empty_r <= 1'b1;
            rlevel_r        <= '0;
            runderflow_r    <= 1'b0;
        end else begin
            rbin_r          <= rbinnext_s;
            rptr_r          <= rgraynext_s;
            // Plain Gray equality: both pointers name the same slot and lap.
            rempty_r        <= (rgraynext_s == rif.r_wptr);
            ralmost_empty_r <= (level_s <= AE_LIMIT);
            rlevel_r        <= level_s;
            runderflow_r    <= runderflow_r | (rif.ren & rempty_r);
        end
    end

    assign rif.raddr         = rbin_r[ASIZE-1:0];
    assign rif.rptr          = rptr_r;
    assign rif.rempty        = rempty_r;
    assign rif.ralmost_empty = ralmost_empty_r;
    assign rif.rlevel        = rlevel_r;
    assign rif.runderflow    = runderflow_r;

endmodule

// File: tb/tb_rptr_empty.sv
// Directed bench for rptr_empty (ASIZE=4, AE_THRESH=2): reset, fill/drain,
// underflow, full depth with wrap, simultaneous pop/write and mid-drain reset.
module tb_rptr_empty;

    logic rclk;
    logic rrst;
    int   checks;
    int   errors;

    rptr_empty_if #(.ASIZE(4)) rif ();

    rptr_empty #(.ASIZE(4), .AE_THRESH(2)) dut (
        .rclk (rclk),
        .rrst (rrst),
        .rif  (rif)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge rclk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic empty, input logic almost,
                           input logic [4:0] level, input logic [4:0] ptr,
                           input logic [3:0] addr, input logic uflow);
        chk({tag, ".rempty"},        32'(rif.rempty),        32'(empty));
        chk({tag, ".ralmost_empty"}, 32'(rif.ralmost_empty), 32'(almost));
        chk({tag, ".rlevel"},        32'(rif.rlevel),        32'(level));
        chk({tag, ".rptr"},          32'(rif.rptr),          32'(ptr));
        chk({tag, ".raddr"},         32'(rif.raddr),         32'(addr));
        chk({tag, ".runderflow"},    32'(rif.runderflow),    32'(uflow));
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rrst       = 1'b1;
        rif.ren    = 1'b0;
        rif.r_wptr = 5'b00000;

        // Reset
        step();
        step();
        chk_all("reset", 1'b1, 1'b1, 5'd0, 5'b00000, 4'd0, 1'b0);
        rrst = 1'b0;
        step();
        chk_all("idle", 1'b1, 1'b1, 5'd0, 5'b00000, 4'd0, 1'b0);

        // Fill to 3 words (gray 3)
        rif.r_wptr = 5'b00010;
        step();
        chk_all("fill3", 1'b0, 1'b0, 5'd3, 5'b00000, 4'd0, 1'b0);

        // Drain 3 words
        rif.ren = 1'b1;
        chk("drain0.raddr", 32'(rif.raddr), 32'd0);
        step();
        chk_all("drain1", 1'b0, 1'b1, 5'd2, 5'b00001, 4'd1, 1'b0);
        step();
        chk_all("drain2", 1'b0, 1'b1, 5'd1, 5'b00011, 4'd2, 1'b0);
        step();
        chk_all("drain3", 1'b1, 1'b1, 5'd0, 5'b00010, 4'd3, 1'b0);

        // Underflow: ren held while empty
        step();
        chk_all("uflow1", 1'b1, 1'b1, 5'd0, 5'b00010, 4'd3, 1'b1);
        step();
        chk_all("uflow2", 1'b1, 1'b1, 5'd0, 5'b00010, 4'd3, 1'b1);
        rif.ren = 1'b0;
        step();
        chk_all("uflow_sticky", 1'b1, 1'b1, 5'd0, 5'b00010, 4'd3, 1'b1);

        // Reset clears underflow and pointers
        rrst = 1'b1;
        step();
        chk_all("reset2", 1'b1, 1'b1, 5'd0, 5'b00000, 4'd0, 1'b0);
        rrst       = 1'b0;
        rif.r_wptr = 5'b00000;
        step();

        // Full depth: write pointer at 16 (gray 11000)
        rif.r_wptr = 5'b11000;
        step();
        chk_all("full16", 1'b0, 1'b0, 5'd16, 5'b00000, 4'd0, 1'b0);
        rif.ren = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("full_drain.raddr", 32'(rif.raddr), 32'(i));
            step();
            chk("full_drain.rlevel", 32'(rif.rlevel), 32'(15 - i));
        end
        rif.ren = 1'b0;
        chk_all("full_done", 1'b1, 1'b1, 5'd0, 5'b11000, 4'd0, 1'b0);

        // Write pointer to 31 (gray 10000), drain 15
        rif.r_wptr = 5'b10000;
        step();
        chk_all("w31", 1'b0, 1'b0, 5'd15, 5'b11000, 4'd0, 1'b0);
        rif.ren = 1'b1;
        for (int i = 0; i < 15; i++) step();
        rif.ren = 1'b0;
        chk_all("r31", 1'b1, 1'b1, 5'd0, 5'b10000, 4'd15, 1'b0);

        // One more write wraps the write pointer to 0, then one pop wraps rbin
        rif.r_wptr = 5'b00000;
        step();
        chk_all("wrap_w", 1'b0, 1'b1, 5'd1, 5'b10000, 4'd15, 1'b0);
        rif.ren = 1'b1;
        step();
        rif.ren = 1'b0;
        chk_all("wrap_r", 1'b1, 1'b1, 5'd0, 5'b00000, 4'd0, 1'b0);

        // Simultaneous pop and write at level 1
        rif.r_wptr = 5'b00001;
        step();
        chk_all("lvl1", 1'b0, 1'b1, 5'd1, 5'b00000, 4'd0, 1'b0);
        rif.ren    = 1'b1;
        rif.r_wptr = 5'b00011;
        step();
        rif.ren = 1'b0;
        chk_all("simul", 1'b0, 1'b1, 5'd1, 5'b00001, 4'd1, 1'b0);

        // Reset mid-drain at level 5; r_wptr change that cycle is ignored
        rif.r_wptr = 5'b00101;
        step();
        chk_all("lvl5", 1'b0, 1'b0, 5'd5, 5'b00001, 4'd1, 1'b0);
        rif.ren    = 1'b1;
        rrst       = 1'b1;
        rif.r_wptr = 5'b00100;
        step();
        chk_all("mid_reset", 1'b1, 1'b1, 5'd0, 5'b00000, 4'd0, 1'b0);
        rrst       = 1'b0;
        rif.ren    = 1'b0;
        rif.r_wptr = 5'b00000;
        step();
        chk_all("post_reset", 1'b1, 1'b1, 5'd0, 5'b00000, 4'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
